output_port_arbiter: RTL
========================

// Module: output_port_arbiter
// PURPOSE
//  Per-output-port connection controller for the 16x16 switch; drives the sel/oe pair of one output I/O cell.
//  Arbitrates 16 level-held input-port requests round-robin, emits the winner's index as Gray-coded sel,
//  and asserts oe only after a break-before-make guard, so sel never changes while the output drives.
//  Holds the connection until the winner releases its request or a hold timeout expires. One instance per output.
// PARAMETERS
//  SETUP_CYC  1    guard cycles with oe=0 after sel update, before connect; legal range >=1
//  MAX_HOLD   256  max CONN cycles before forced release; 0 = no timeout
// PORTS
//  clk    in   1   single clock, rising edge
//  rst_n  in   1   asynchronous, active-low reset
//  req    in   16  req[i]=1: input port i requests this output; level, held for whole transfer
//  gnt    out  16  one-hot grant to the connected input; 0 when not connected
//  sel    out  4   Gray-coded winner index to the I/O cell: sel = i ^ (i>>1)
//  oe     out  1   output enable to the I/O cell
//  busy   out  1   FSM not in IDLE
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset values: sel=4'b0000, oe=0, gnt=16'h0000, busy=0, state=IDLE, rr_ptr=15 (input 0 has first priority),
//    counters=0. rst_n low mid-connection drops oe and gnt immediately, with no clock edge.
//  - All outputs are registered. busy = (state!=IDLE).
//  - FSM: IDLE -> GUARD -> CONN -> RELEASE -> IDLE.
//  - IDLE: oe=0, gnt=0, sel holds its last value.
//    On an edge with req!=0: winner w = first set bit searching from rr_ptr+1 upward, mod 16.
//    At that edge: sel<=gray(w), gcnt<=SETUP_CYC-1, go to GUARD.
//  - GUARD: oe=0, gnt=0. If gcnt==0: oe<=1, gnt<=1<<w, hcnt<=0, go to CONN; else gcnt--.
//    The winner's req is not rechecked in GUARD; a drop is seen in CONN.
//  - Latency: req seen at edge k -> sel valid after edge k; oe/gnt high after edge k+SETUP_CYC.
//  - CONN: oe=1, gnt one-hot. hcnt++ each cycle.
//    Release when req[w]==0, or when MAX_HOLD!=0 and hcnt==MAX_HOLD-1.
//    At the release edge: oe<=0, gnt<=0, rr_ptr<=w, go to RELEASE.
//    So oe is high exactly MAX_HOLD cycles on timeout.
//  - RELEASE: one cycle, oe=0, no arbitration, then IDLE.
//    Minimum oe-low gap between connections = 2+SETUP_CYC cycles.
//  - Non-winner requests in GUARD/CONN/RELEASE are ignored (no queueing) and re-arbitrated in IDLE.
//    A timed-out winner still requesting competes again with lowest priority.
//  - Invariants:
//    - sel changes only on the IDLE->GUARD edge, never while oe=1.
//    - gnt is onehot0; gnt!=0 iff oe=1.
//    - When oe=1: gnt == 1<<gray2bin(sel).
//  - Widths: gcnt sized for SETUP_CYC; hcnt = $clog2(MAX_HOLD+1) bits, never wraps (release first).
// STRUCTURE
//  - Shared package switch_pkg:
//    - N_PORTS=16, SEL_W=4
//    - state encoding (IDLE/GUARD/CONN/RELEASE)
//    - functions bin2gray/gray2bin, reused by the I/O cell bench.
//  - Sub-module rr_arbiter (combinational): req[15:0] + ptr[3:0] -> winner index[3:0], valid.
//  - Top holds the FSM, counters, rr_ptr and output registers.
// TESTING
//  - Reset, SETUP_CYC=1, req=16'h0001 at edge 0 -> sel=0000 after edge 0; oe=1, gnt=0001 after edge 1.
//  - Gray map: req=16'h0004 -> sel=0011; req=16'h0010 -> sel=0110; req=16'h8000 -> sel=1000.
//  - Fairness: req=16'h0011 from reset -> input 0 first. Drop req[0] -> RELEASE, then input 4 (sel=0110).
//    oe low >=3 cycles between connections.
//  - Timeout, MAX_HOLD=8: req[5] held plus req[6] -> oe high exactly 8 cycles, then gnt=16'h0040, sel=0101.
//  - Async reset: rst_n low during CONN with clk stopped -> oe=0, gnt=0, sel=0000, busy=0 at once.
//  - 10k cycles of random req, assert every cycle:
//    - sel stable while oe=1
//    - gnt onehot0 and gnt==1<<gray2bin(sel) when oe=1
//    - no starvation: any held req granted within 16*(MAX_HOLD+2+SETUP_CYC) cycles.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants, FSM state encoding and Gray helpers for the 16x16 switch
package switch_pkg;

    localparam int N_PORTS = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GUARD   = 2'd1,
        ST_CONN    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic logic [SEL_W-1:0] bin2gray(input logic [SEL_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [SEL_W-1:0] gray2bin(input logic [SEL_W-1:0] g);
        logic [SEL_W-1:0] b;
        b[SEL_W-1] = g[SEL_W-1];
        for (int i = SEL_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request above ptr, wrapping mod 16
module rr_arbiter
    import switch_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   index,
    output logic               valid
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        index = '0;
        valid = 1'b0;
        idx   = '0;
        // offset 16 wraps to ptr itself, so the previous winner is searched last
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = ptr + SEL_W'(k);
            if (!valid && req[idx]) begin
                index = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - per-output connection FSM: round-robin pick, Gray sel, break-before-make oe
module output_port_arbiter
    import switch_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int MAX_HOLD  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               oe,
    output logic               busy
);

    localparam int GCNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int HCNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(SETUP_CYC - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST  = HCNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit TIMEOUT_EN = (MAX_HOLD > 0);

    state_t             state;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   winner;
    logic [GCNT_W-1:0]  gcnt;
    logic [HCNT_W-1:0]  hcnt;
    logic [SEL_W-1:0]   arb_index;
    logic               arb_valid;

    rr_arbiter u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .index (arb_index),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '1;
            winner <= '0;
            gcnt   <= '0;
            hcnt   <= '0;
            sel    <= '0;
            oe     <= 1'b0;
            gnt    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        sel    <= bin2gray(arb_index);
                        winner <= arb_index;
                        gcnt   <= GUARD_LAST;
                        busy   <= 1'b1;
                        state  <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // sel has already settled for at least one cycle before oe rises
                    if (gcnt == '0) begin
                        oe    <= 1'b1;
                        gnt   <= N_PORTS'(1) << winner;
                        hcnt  <= '0;
                        state <= ST_CONN;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                ST_CONN: begin
                    if (!req[winner] || (TIMEOUT_EN && hcnt == HOLD_LAST)) begin
                        oe     <= 1'b0;
                        gnt    <= '0;
                        rr_ptr <= winner;
                        state  <= ST_RELEASE;
                    end else if (TIMEOUT_EN) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
